// File: rtl/activation_pkg.sv
// Shared activation types and the ReLU positivity test used by both the
// forward activation and its backward gradient gate.
package activation_pkg;

    localparam int VECTOR_LEN = 4;
    localparam int DATA_WIDTH = 32;

    typedef logic [VECTOR_LEN-1:0][DATA_WIDTH-1:0] vector_t;
    typedef logic [VECTOR_LEN-1:0]                 mask_t;

    // A lane counts as positive only for a strictly positive, non-NaN value.
    // Positive denormals and +inf are positive.
    function automatic logic relu_mask_bit(input logic [31:0] value);
        logic is_nan;
        is_nan = (value[30:23] == 8'hFF) && (value[22:0] != 23'd0);
        return !value[31] && (value[30:0] != 31'd0) && !is_nan;
    endfunction

endpackage

// File: rtl/relu_mask_fifo.sv
// Synchronous FIFO holding per-vector ReLU masks between the forward and
// backward passes. Pushes while full and pops while empty are ignored.
module relu_mask_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // NOTE: state updates use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: the storage array is deliberately not reset; count gates every
    // read, so stale entries are never observed and the array stays plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/relu_grad.sv
// Backward ReLU: records forward positivity masks in FIFO order and gates
// each upstream gradient vector with the oldest stored mask.
module relu_grad #(
    parameter int VECTOR_LEN = activation_pkg::VECTOR_LEN,
    parameter int DATA_WIDTH = activation_pkg::DATA_WIDTH,
    parameter int MASK_DEPTH = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush,
    input  logic                                   fwd_valid,
    output logic                                   fwd_ready,
    input  logic [VECTOR_LEN-1:0][DATA_WIDTH-1:0]  fwd_data,
    input  logic                                   grad_in_valid,
    output logic                                   grad_in_ready,
    input  logic [VECTOR_LEN-1:0][DATA_WIDTH-1:0]  grad_in,
    output logic                                   grad_out_valid,
    input  logic                                   grad_out_ready,
    output logic [VECTOR_LEN-1:0][DATA_WIDTH-1:0]  grad_out,
    output logic [$clog2(MASK_DEPTH):0]            mask_count
);

    import activation_pkg::*;

    logic [VECTOR_LEN-1:0]                 fwd_mask;
    logic [VECTOR_LEN-1:0]                 head_mask;
    logic [VECTOR_LEN-1:0][DATA_WIDTH-1:0] gated;
    logic                                  fifo_full;
    logic                                  fifo_empty;
    logic                                  grad_fire;

    // fwd_ready depends only on the registered count, never on the grad side.
    assign fwd_ready     = !fifo_full;
    assign grad_in_ready = !fifo_empty && (!grad_out_valid || grad_out_ready);
    assign grad_fire     = grad_in_valid && grad_in_ready;

    // NOTE: defaults first so no path through the combinational block can
    // leave a bit unassigned and infer a latch.
    always_comb begin
        fwd_mask = '0;
        gated    = '0;
        for (int i = 0; i < VECTOR_LEN; i++) begin
            fwd_mask[i] = relu_mask_bit(fwd_data[i]);
            gated[i]    = head_mask[i] ? grad_in[i] : '0;
        end
    end

    relu_mask_fifo #(
        .WIDTH (VECTOR_LEN),
        .DEPTH (MASK_DEPTH)
    ) u_mask_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (fwd_valid),
        .push_data (fwd_mask),
        .pop       (grad_fire),
        .pop_data  (head_mask),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (mask_count)
    );

    // Output register holds while stalled; an accept can refill it in the
    // same cycle the previous vector is handed off.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            grad_out_valid <= 1'b0;
            grad_out       <= '0;
        end else if (grad_fire) begin
            grad_out_valid <= 1'b1;
            grad_out       <= gated;
        end else if (grad_out_ready) begin
            grad_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_relu_grad.sv
// Directed bench for relu_grad: stimulus queues hand-computed expected
// gradients; a negedge monitor pops and compares on each output handshake.
module tb_relu_grad;

    localparam int VL = 4;
    localparam int DW = 32;
    localparam int MD = 8;

    typedef logic [VL-1:0][DW-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush;
    logic       fwd_valid;
    logic       fwd_ready;
    vec_t       fwd_data;
    logic       grad_in_valid;
    logic       grad_in_ready;
    vec_t       grad_in;
    logic       grad_out_valid;
    logic       grad_out_ready;
    vec_t       grad_out;
    logic [3:0] mask_count;

    int   checks = 0;
    int   errors = 0;
    vec_t sb[$];

    always #5 clk = ~clk;

    relu_grad #(
        .VECTOR_LEN (VL),
        .DATA_WIDTH (DW),
        .MASK_DEPTH (MD)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .fwd_valid      (fwd_valid),
        .fwd_ready      (fwd_ready),
        .fwd_data       (fwd_data),
        .grad_in_valid  (grad_in_valid),
        .grad_in_ready  (grad_in_ready),
        .grad_in        (grad_in),
        .grad_out_valid (grad_out_valid),
        .grad_out_ready (grad_out_ready),
        .grad_out       (grad_out),
        .mask_count     (mask_count)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t vec4(input logic [31:0] l0, input logic [31:0] l1,
                                  input logic [31:0] l2, input logic [31:0] l3);
        vec_t v;
        v[0] = l0; v[1] = l1; v[2] = l2; v[3] = l3;
        return v;
    endfunction

    // +1.0 on lanes whose mask bit is set, -1.0 elsewhere.
    function automatic vec_t fwd_of(input logic [3:0] m);
        vec_t v;
        for (int i = 0; i < VL; i++) v[i] = m[i] ? 32'h3F80_0000 : 32'hBF80_0000;
        return v;
    endfunction

    function automatic vec_t gate(input logic [3:0] m, input vec_t g);
        vec_t v;
        for (int i = 0; i < VL; i++) v[i] = m[i] ? g[i] : 32'h0;
        return v;
    endfunction

    function automatic vec_t grad_pat(input int k);
        vec_t v;
        for (int i = 0; i < VL; i++) v[i] = 32'h4000_0000 + 32'(k * 16 + i);
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fwd(input vec_t v);
        logic r;
        fwd_valid = 1'b1;
        fwd_data  = v;
        for (int n = 0; n < 50; n++) begin
            r = fwd_ready;
            step();
            if (r) begin
                fwd_valid = 1'b0;
                return;
            end
        end
        fwd_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL push_timeout: fwd_ready stayed low for 50 cycles");
    endtask

    task automatic send_grad(input vec_t g, input vec_t e);
        logic r;
        grad_in_valid = 1'b1;
        grad_in       = g;
        for (int n = 0; n < 50; n++) begin
            r = grad_in_ready;
            if (r) sb.push_back(e);
            step();
            if (r) begin
                grad_in_valid = 1'b0;
                return;
            end
        end
        grad_in_valid = 1'b0;
        checks++;
        errors++;
        $display("FAIL grad_timeout: grad_in_ready stayed low for 50 cycles");
    endtask

    task automatic drain();
        for (int n = 0; n < 100; n++) begin
            if (sb.size() == 0 && !grad_out_valid) return;
            step();
        end
        checks++;
        errors++;
        $display("FAIL drain_timeout: %0d outputs still expected", sb.size());
    endtask

    // Monitor: every output handshake must match the oldest expected vector.
    always @(negedge clk) begin
        if (!rst && !flush && grad_out_valid && grad_out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_out: got %h with nothing expected", grad_out);
            end else begin
                check("grad_out", grad_out, sb.pop_front());
            end
        end
    end

    logic [3:0] fm [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011,
                           4'b1100, 4'b1111, 4'b0000, 4'b0101};
    logic [3:0] st [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    vec_t held;
    vec_t ones;

    initial begin
        rst = 1'b1; flush = 1'b0;
        fwd_valid = 1'b0; fwd_data = '0;
        grad_in_valid = 1'b0; grad_in = '0;
        grad_out_ready = 1'b1;
        ones = vec4(32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000);
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_count", mask_count, 0);
        check("rst_fwd_ready", fwd_ready, 1);
        check("rst_grad_in_ready", grad_in_ready, 0);
        check("rst_out_valid", grad_out_valid, 0);
        check("rst_out_data", grad_out, 0);

        // Basic gating
        push_fwd(vec4(32'hBF80_0000, 32'h3F80_0000, 32'hC000_0000, 32'h4000_0000));
        check("basic_count1", mask_count, 1);
        send_grad(vec4(32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000, 32'h3F00_0000),
                  vec4(32'h0, 32'h3F00_0000, 32'h0, 32'h3F00_0000));
        check("basic_count0", mask_count, 0);
        check("basic_latency", grad_out_valid, 1);
        drain();

        // Edge encodings: -0, +0, NaN, +inf; then denormal, -inf, sNaN, min normal
        push_fwd(vec4(32'h8000_0000, 32'h0000_0000, 32'h7FC0_0000, 32'h7F80_0000));
        send_grad(vec4(32'h4040_0000, 32'h4040_0000, 32'h4040_0000, 32'h4040_0000),
                  vec4(32'h0, 32'h0, 32'h0, 32'h4040_0000));
        push_fwd(vec4(32'h0000_0001, 32'hFF80_0000, 32'h7F80_0001, 32'h0080_0000));
        send_grad(vec4(32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h7FC0_0001),
                  vec4(32'h1111_1111, 32'h0, 32'h0, 32'h7FC0_0001));
        drain();

        // Fill the store, hold a 9th push, pop one
        for (int k = 0; k < MD; k++) push_fwd(fwd_of(fm[k]));
        check("full_count", mask_count, 8);
        check("full_fwd_ready", fwd_ready, 0);
        fwd_valid = 1'b1;
        fwd_data  = fwd_of(fm[8]);
        repeat (3) step();
        check("full_held_count", mask_count, 8);
        grad_in_valid = 1'b1;
        grad_in       = grad_pat(0);
        check("full_pop_ready", grad_in_ready, 1);
        check("full_pop_fwd_ready", fwd_ready, 0);
        sb.push_back(gate(fm[0], grad_pat(0)));
        step();
        grad_in_valid = 1'b0;
        check("after_pop_fwd_ready", fwd_ready, 1);
        check("after_pop_count", mask_count, 7);
        step();
        fwd_valid = 1'b0;
        check("refill_count", mask_count, 8);

        // Output backpressure for 3 cycles
        grad_out_ready = 1'b0;
        grad_in_valid  = 1'b1;
        grad_in        = grad_pat(1);
        check("hold_accept_ready", grad_in_ready, 1);
        sb.push_back(gate(fm[1], grad_pat(1)));
        held = gate(fm[1], grad_pat(1));
        step();
        grad_in = grad_pat(2);
        for (int c = 0; c < 3; c++) begin
            check("hold_valid", grad_out_valid, 1);
            check("hold_data", grad_out, held);
            check("hold_grad_in_ready", grad_in_ready, 0);
            step();
        end
        grad_in_valid  = 1'b0;
        grad_out_ready = 1'b1;
        step();
        for (int k = 2; k < 9; k++) send_grad(grad_pat(k), gate(fm[k], grad_pat(k)));
        drain();
        check("full_drained_count", mask_count, 0);

        // Ordering and streaming with concurrent pushes
        for (int k = 0; k < 4; k++) push_fwd(fwd_of(st[k]));
        for (int k = 0; k < 4; k++) begin
            grad_in_valid = 1'b1;
            grad_in       = ones;
            fwd_valid     = 1'b1;
            fwd_data      = fwd_of(4'hF);
            check("stream_grad_ready", grad_in_ready, 1);
            check("stream_fwd_ready", fwd_ready, 1);
            check("stream_count", mask_count, 4);
            if (k > 0) check("stream_out_valid", grad_out_valid, 1);
            sb.push_back(gate(st[k], ones));
            step();
        end
        grad_in_valid = 1'b0;
        fwd_valid     = 1'b0;
        check("stream_end_count", mask_count, 4);
        check("stream_last_valid", grad_out_valid, 1);
        for (int k = 0; k < 4; k++) send_grad(grad_pat(20 + k), grad_pat(20 + k));
        drain();

        // Empty stall then a push releases the gradient
        grad_in_valid = 1'b1;
        grad_in       = grad_pat(30);
        for (int c = 0; c < 5; c++) begin
            check("stall_grad_ready", grad_in_ready, 0);
            check("stall_out_valid", grad_out_valid, 0);
            step();
        end
        fwd_valid = 1'b1;
        fwd_data  = fwd_of(4'b1010);
        check("stall_push_cycle_ready", grad_in_ready, 0);
        step();
        fwd_valid = 1'b0;
        check("stall_count", mask_count, 1);
        check("stall_release_ready", grad_in_ready, 1);
        sb.push_back(gate(4'b1010, grad_pat(30)));
        step();
        grad_in_valid = 1'b0;
        check("stall_out_valid_after", grad_out_valid, 1);
        drain();

        // Reset, then flush, with a stalled output and 3 stored masks
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) push_fwd(fwd_of(4'hF));
            grad_out_ready = 1'b0;
            send_grad(grad_pat(40 + p), grad_pat(40 + p));
            check("pre_clear_count", mask_count, 3);
            check("pre_clear_valid", grad_out_valid, 1);
            if (p == 0) rst = 1'b1;
            else        flush = 1'b1;
            sb.delete();
            step();
            rst   = 1'b0;
            flush = 1'b0;
            check("clear_count", mask_count, 0);
            check("clear_valid", grad_out_valid, 0);
            check("clear_data", grad_out, 0);
            check("clear_fwd_ready", fwd_ready, 1);
            check("clear_grad_in_ready", grad_in_ready, 0);
            grad_out_ready = 1'b1;
            step();
        end

        drain();
        check("sb_empty", 128'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
